// File: rtl/jk_pulse_sequencer.sv
// jk_pulse_sequencer
// Accepts one command at a time: a JK operation, a pulse count and an
// inter-pulse gap. It then drives that many single-cycle enable pulses into a
// downstream enabled JK stage, spaced by the gap. A shadow copy of the JK
// output is kept so that upstream logic can read the predicted q without a
// feedback path.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted this cycle
//   cmd_op     in   {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
//   cmd_count  in   pulse count, 0 means 2^CNT_W
//   cmd_gap    in   idle cycles between pulses, 0 means back-to-back
//   cmd_abort  in   terminate the current command
//   en, j, k   out  JK stage drive; j/k are forced low when en is low
//   busy       out  command in progress
//   done       out  one-cycle pulse on normal completion
//   q_shadow   out  predicted JK q after all pulses issued so far
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready may be high
// PULSE | one enable cycle with {j,k} = latched op
// GAP   | idle spacing between pulses, gap counter running down to 1

module jk_pulse_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [CNT_W-1:0] cmd_gap,
    input  logic             cmd_abort,
    output logic             en,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             q_shadow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [CNT_W:0]   REM_ONE  = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   REM_FULL = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W-1:0] GAP_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_ZERO = '0;

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] gap_r;
    logic [CNT_W:0]   rem;
    logic [CNT_W-1:0] gap_cnt;
    logic             done_r;
    logic             q_r;
    logic             accept;
    logic             q_next;

    assign cmd_ready = (state == ST_IDLE) & ~cmd_abort & ~reset;
    assign accept    = cmd_valid & cmd_ready;

    // Outputs decode only from registered state, never from cmd_* inputs.
    assign en       = (state == ST_PULSE);
    assign j        = en & op_r[1];
    assign k        = en & op_r[0];
    assign busy     = (state == ST_PULSE) | (state == ST_GAP);
    assign done     = done_r;
    assign q_shadow = q_r;

    always_comb begin
        q_next = q_r;
        case (op_r)
            2'b00:   q_next = q_r;
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            default: q_next = ~q_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_r    <= 2'b00;
            gap_r   <= '0;
            rem     <= '0;
            gap_cnt <= '0;
            done_r  <= 1'b0;
            q_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_r  <= cmd_op;
                        gap_r <= cmd_gap;
                        rem   <= (cmd_count == GAP_ZERO) ? REM_FULL : {1'b0, cmd_count};
                        state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    // The pulse is issued even if abort lands in this cycle.
                    q_r <= q_next;
                    rem <= rem - REM_ONE;
                    if (cmd_abort) begin
                        state <= ST_IDLE;
                    end else if (rem == REM_ONE) begin
                        state  <= ST_IDLE;
                        done_r <= 1'b1;
                    end else if (gap_r == GAP_ZERO) begin
                        state <= ST_PULSE;
                    end else begin
                        state   <= ST_GAP;
                        gap_cnt <= gap_r;
                    end
                end
                ST_GAP: begin
                    if (cmd_abort) begin
                        state <= ST_IDLE;
                    end else if (gap_cnt == GAP_ONE) begin
                        state <= ST_PULSE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
